// File: rtl/bm_nibble_word_decoder_pkg.sv
// Shared defaults and state encoding for the nibble word decoder and its
// companion encoder bench.
package bm_nibble_word_decoder_pkg;

  localparam int DEF_BITS = 4;
  localparam int DEF_NIBS = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/bm_nibble_inv.sv
// Purely combinational complement decode: value = ~code over BITS bits.
module bm_nibble_inv #(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0] code,
  output logic [BITS-1:0] value
);

  assign value = ~code;

endmodule

// File: rtl/bm_nibble_word_decoder.sv
// Decodes a stream of complement-encoded nibbles and assembles NIBS of them
// into one word, first nibble in the MSBs, held until the consumer takes it.
module bm_nibble_word_decoder
  import bm_nibble_word_decoder_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int NIBS = DEF_NIBS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic [BITS-1:0]      in_code,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITS*NIBS-1:0] out_data,
  output logic                 err
);

  localparam int W  = BITS * NIBS;
  localparam int CW = $clog2(NIBS + 1);

  // Handshake: a nibble transfers on any rising edge where in_valid and
  // in_ready are both high; a word transfers where out_valid and out_ready are.
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [W-1:0]    data_q, data_d;
  logic            err_q, err_d;
  logic [BITS-1:0] value;
  logic [W-1:0]    shifted;
  logic            accept;

  bm_nibble_inv #(.BITS(BITS)) u_inv (
    .code  (in_code),
    .value (value)
  );

  // Readiness follows state only; held low while reset is asserted.
  assign in_ready  = !reset && (state_q == ST_IDLE || state_q == ST_COLLECT);
  assign accept    = in_valid && in_ready;
  assign shifted   = {shift_q[W-BITS-1:0], value};
  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = data_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_first) begin
            shift_d = shifted;
            cnt_d   = CW'(1);
            state_d = ST_COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (accept) begin
          shift_d = shifted;
          if (in_first) begin
            // Framing error: the partial word is abandoned, this nibble restarts it.
            cnt_d = CW'(1);
            err_d = 1'b1;
          end else if (cnt_q == CW'(NIBS - 1)) begin
            data_d  = shifted;
            cnt_d   = '0;
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule
